// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V core front end: reset PC, NOP encoding,
// next-PC select codes and the layout of the packed decode control bundle.
package riscv_pkg;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_JALR = 2'b10;

    // Control bundle: {regwrite, resultsrc[1:0], memwrite, jump, branch, alucontrol[3:0], alusrc[1:0]}
    localparam int CTRL_W            = 12;
    localparam int CTRL_REGWRITE     = 11;
    localparam int CTRL_RESULTSRC_LO = 9;
    localparam int CTRL_MEMWRITE     = 8;
    localparam int CTRL_JUMP         = 7;
    localparam int CTRL_BRANCH       = 6;
    localparam int CTRL_ALUCTRL_LO   = 2;
    localparam int CTRL_ALUSRC_LO    = 0;
endpackage

// File: rtl/sat_counter.sv
// Event counter that counts cycles with inc high and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX pipeline registers with hazard stall/flush handling
// and saturating hazard event counters.
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int          CTRL_W   = riscv_pkg::CTRL_W,
    parameter int          CNT_W    = 32,
    parameter logic [31:0] NOP      = riscv_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallF,
    input  logic              stallD,
    input  logic              flushD,
    input  logic              flushE,
    input  logic [1:0]        pcsrcE,
    input  logic              jalD,
    input  logic [31:0]       PCTargetE,
    input  logic [31:0]       ALUResultE,
    input  logic [31:0]       PCTargetD,
    input  logic [31:0]       InstrF,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       ImmExtD,
    output logic [31:0]       PCF,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCD,
    output logic [31:0]       PCPlus4D,
    output logic              validD,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       ImmExtE,
    output logic [31:0]       PCE,
    output logic [31:0]       PCPlus4E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic              validE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flushD_cnt,
    output logic [CNT_W-1:0]  flushE_cnt
);
    import riscv_pkg::*;

    logic [31:0] pc_plus4;
    logic [31:0] pc_next;

    assign pc_plus4 = PCF + 32'd4;

    // E-stage redirects outrank a decode-resolved jal; code 11 aliases the branch target.
    always_comb begin
        pc_next = pc_plus4;
        if (pcsrcE == PCSRC_JALR)
            pc_next = ALUResultE;
        else if (pcsrcE != PCSRC_SEQ)
            pc_next = PCTargetE;
        else if (jalD)
            pc_next = PCTargetD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            PCF <= RESET_PC;
        else if (!stallF)
            PCF <= pc_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || 1'b0) begin
            InstrD   <= NOP;
            PCD      <= '0;
            PCPlus4D <= '0;
            validD   <= 1'b0;
        end else if (flushD) begin
            InstrD   <= NOP;
            PCD      <= '0;
            PCPlus4D <= '0;
            validD   <= 1'b0;
        end else if (!stallD) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= pc_plus4;
            validD   <= 1'b1;
        end
    end

    // A decode stall must bubble E, otherwise the held instruction would issue twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrlE    <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            validE   <= 1'b0;
        end else if (flushE || stallD) begin
            ctrlE    <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            validE   <= 1'b0;
        end else begin
            ctrlE    <= ctrlD;
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            ImmExtE  <= ImmExtD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= InstrD[19:15];
            Rs2E     <= InstrD[24:20];
            RdE      <= InstrD[11:7];
            validE   <= validD;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .inc(stallD), .cnt(stall_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_flushd_cnt (
        .clk(clk), .rst(rst), .inc(flushD), .cnt(flushD_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_flushe_cnt (
        .clk(clk), .rst(rst), .inc(flushE), .cnt(flushE_cnt)
    );
endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: directed hazard scenarios plus random traffic
// checked every cycle against a cycle-level reference model.
module tb_pipe_front_regs;
    localparam int          CW   = 8;
    localparam int          CMAX = (1 << CW) - 1;
    localparam logic [31:0] NOPI = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF, stallD, flushD, flushE, jalD;
    logic [1:0]  pcsrcE;
    logic [31:0] PCTargetE, ALUResultE, PCTargetD, InstrF, RD1D, RD2D, ImmExtD;
    logic [11:0] ctrlD;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D, RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic        validD, validE;
    logic [11:0] ctrlE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [CW-1:0] stall_cnt, flushD_cnt, flushE_cnt;

    pipe_front_regs #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .flushE(flushE), .pcsrcE(pcsrcE), .jalD(jalD), .PCTargetE(PCTargetE),
        .ALUResultE(ALUResultE), .PCTargetD(PCTargetD), .InstrF(InstrF), .ctrlD(ctrlD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCF(PCF), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .validD(validD), .ctrlE(ctrlE), .RD1E(RD1E),
        .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E),
        .Rs2E(Rs2E), .RdE(RdE), .validE(validE), .stall_cnt(stall_cnt),
        .flushD_cnt(flushD_cnt), .flushE_cnt(flushE_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: architectural contents of each pipeline register.
    logic [31:0] m_pcf, m_instrd, m_pcd, m_p4d;
    logic        m_vd, m_ve;
    logic [11:0] m_ctrle;
    logic [31:0] m_rd1e, m_rd2e, m_imme, m_pce, m_p4e;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    int          m_cnt[3];

    task automatic model_reset();
        m_pcf = 32'h0; m_instrd = NOPI; m_pcd = 0; m_p4d = 0; m_vd = 0;
        m_ctrle = 0; m_rd1e = 0; m_rd2e = 0; m_imme = 0; m_pce = 0; m_p4e = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ve = 0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    endtask

    task automatic model_clk();
        logic [31:0] target;
        // ID/EX from the old D contents
        if (flushE || stallD) begin
            m_ctrle = 0; m_rd1e = 0; m_rd2e = 0; m_imme = 0; m_pce = 0; m_p4e = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ve = 0;
        end else begin
            m_ctrle = ctrlD; m_rd1e = RD1D; m_rd2e = RD2D; m_imme = ImmExtD;
            m_pce = m_pcd; m_p4e = m_p4d; m_ve = m_vd;
            m_rs1 = m_instrd[19:15]; m_rs2 = m_instrd[24:20]; m_rd = m_instrd[11:7];
        end
        // IF/ID from the old PC
        if (flushD) begin
            m_instrd = NOPI; m_pcd = 0; m_p4d = 0; m_vd = 0;
        end else if (!stallD) begin
            m_instrd = InstrF; m_pcd = m_pcf; m_p4d = m_pcf + 4; m_vd = 1;
        end
        if (pcsrcE == 2'b10)      target = ALUResultE;
        else if (pcsrcE != 2'b00) target = PCTargetE;
        else if (jalD)            target = PCTargetD;
        else                      target = m_pcf + 4;
        if (!stallF) m_pcf = target;
        if (stallD && m_cnt[0] < CMAX) m_cnt[0]++;
        if (flushD && m_cnt[1] < CMAX) m_cnt[1]++;
        if (flushE && m_cnt[2] < CMAX) m_cnt[2]++;
    endtask

    task automatic check_all();
        chk("PCF", PCF, m_pcf);
        chk("InstrD", InstrD, m_instrd);
        chk("PCD", PCD, m_pcd);
        chk("PCPlus4D", PCPlus4D, m_p4d);
        chk("validD", validD, m_vd);
        chk("ctrlE", ctrlE, m_ctrle);
        chk("RD1E", RD1E, m_rd1e);
        chk("RD2E", RD2E, m_rd2e);
        chk("ImmExtE", ImmExtE, m_imme);
        chk("PCE", PCE, m_pce);
        chk("PCPlus4E", PCPlus4E, m_p4e);
        chk("Rs1E", Rs1E, m_rs1);
        chk("Rs2E", Rs2E, m_rs2);
        chk("RdE", RdE, m_rd);
        chk("validE", validE, m_ve);
        chk("stall_cnt", stall_cnt, m_cnt[0]);
        chk("flushD_cnt", flushD_cnt, m_cnt[1]);
        chk("flushE_cnt", flushE_cnt, m_cnt[2]);
    endtask

    task automatic idle();
        stallF = 0; stallD = 0; flushD = 0; flushE = 0; jalD = 0; pcsrcE = 2'b00;
        PCTargetE = 0; ALUResultE = 0; PCTargetD = 0; ctrlD = 0;
        RD1D = 0; RD2D = 0; ImmExtD = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_clk();
        #1 check_all();
    endtask

    initial begin
        idle();
        InstrF = 32'h0050_0093;
        rst = 1'b1;
        model_reset();
        #2 check_all();
        #10 rst = 1'b0;

        // Free-running fetch
        for (int i = 0; i < 3; i++) step();
        chk("free_pc12", PCF, 32'd12);
        chk("free_validD", validD, 1'b1);
        chk("free_validE", validE, 1'b1);

        // Load-use stall
        InstrF = 32'h0000_A103; RD1D = 32'h11; ctrlD = 12'hABC;
        step();
        stallF = 1; stallD = 1;
        step();
        chk("lu_instrD", InstrD, 32'h0000_A103);
        chk("lu_validE", validE, 1'b0);
        chk("lu_rdE", RdE, 5'd0);
        chk("lu_stall_cnt", stall_cnt, 8'd1);
        idle(); step();

        // Branch taken with D/E flush
        pcsrcE = 2'b01; PCTargetE = 32'h40; flushD = 1; flushE = 1;
        step();
        chk("br_pc", PCF, 32'h40);
        chk("br_instrD", InstrD, NOPI);
        chk("br_flushD_cnt", flushD_cnt, 8'd1);
        idle();

        // jalr in E beats jal in D
        pcsrcE = 2'b10; ALUResultE = 32'h100; jalD = 1; PCTargetD = 32'h80;
        step();
        chk("jalr_pc", PCF, 32'h100);
        pcsrcE = 2'b11; PCTargetE = 32'h200; ALUResultE = 32'h300;
        step();
        chk("pcsrc11_pc", PCF, 32'h200);
        idle(); jalD = 1; PCTargetD = 32'h80;
        step();
        chk("jalD_pc", PCF, 32'h80);
        idle(); step();

        // Flush wins over stall in IF/ID
        stallD = 1; flushD = 1;
        step();
        chk("sf_instrD", InstrD, NOPI);
        chk("sf_validD", validD, 1'b0);
        idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            stallF = ($urandom_range(5) == 0);
            stallD = stallF ? ($urandom_range(3) != 0) : ($urandom_range(9) == 0);
            flushD = ($urandom_range(7) == 0);
            flushE = ($urandom_range(7) == 0);
            pcsrcE = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
            jalD = ($urandom_range(7) == 0);
            PCTargetE = $urandom & ~32'h3; ALUResultE = $urandom & ~32'h3;
            PCTargetD = $urandom & ~32'h3; InstrF = $urandom;
            ctrlD = 12'($urandom); RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
            step();
        end
        idle();

        // Wrap of PC+4 at the top of the address space
        pcsrcE = 2'b01; PCTargetE = 32'hFFFF_FFFC;
        step();
        idle(); step();
        chk("pc_wrap", PCF, 32'h0);

        // Asynchronous reset mid-cycle while stalled
        stallF = 1; stallD = 1; flushE = 1;
        step();
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        chk("arst_pc", PCF, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        step();

        // Counter saturation
        stallD = 1;
        for (int i = 0; i < CMAX + 2; i++) step();
        chk("sat_cnt", stall_cnt, 8'hFF);
        idle(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
